// File: rtl/digit_seq_mul_if.sv
// Handshake and building-block bus for the digit-serial multiplier sequencer.
// Optional macro PSMAC_ACC_EN adds acc_clr and widens result by 4 guard bits.
interface digit_seq_mul_if #(
  parameter int unsigned OPW = 8
);
`ifdef PSMAC_ACC_EN
  localparam int unsigned RES_W = 2 * OPW + 4;
`else
  localparam int unsigned RES_W = 2 * OPW;
`endif

  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   a;
  logic [OPW-1:0]   b;
  logic             sgn_a;
  logic             sgn_b;
  logic [1:0]       prec;
  logic [1:0]       md;
  logic [1:0]       mr;
  logic             sx;
  logic             sy;
  logic [4:0]       p;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] result;
`ifdef PSMAC_ACC_EN
  logic             acc_clr;

  modport slave (
    input  in_valid, a, b, sgn_a, sgn_b, prec, p, out_ready, acc_clr,
    output in_ready, md, mr, sx, sy, out_valid, result
  );

  modport master (
    output in_valid, a, b, sgn_a, sgn_b, prec, p, out_ready, acc_clr,
    input  in_ready, md, mr, sx, sy, out_valid, result
  );
`else
  modport slave (
    input  in_valid, a, b, sgn_a, sgn_b, prec, p, out_ready,
    output in_ready, md, mr, sx, sy, out_valid, result
  );

  modport master (
    output in_valid, a, b, sgn_a, sgn_b, prec, p, out_ready,
    input  in_ready, md, mr, sx, sy, out_valid, result
  );
`endif
endinterface

// File: rtl/digit_seq_mul.sv
// Digit-serial precision-scalable multiplier sequencer. Walks every 2-bit digit pair of the
// captured operands through an external 2x2 signed/unsigned block and accumulates the
// shifted partial products. Optional macro PSMAC_ACC_EN turns the product register into a
// running accumulator (cleared only on acc_clr) with a raw ACC_W-bit result.
module digit_seq_mul #(
  parameter int unsigned OPW = 8
) (
  input  logic          clk,
  input  logic          rst,
  digit_seq_mul_if.slave bus
);
  localparam int unsigned RW = 2 * OPW;
`ifdef PSMAC_ACC_EN
  localparam int unsigned ACC_W = RW + 4;
  localparam int unsigned AW    = ACC_W;
`else
  localparam int unsigned AW    = RW;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic           ready_q, ready_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d;
  logic           sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d;
  logic [1:0]     prec_q, prec_d;
  logic [2:0]     i_q, i_d, j_q, j_d;
  logic [AW-1:0]  acc_q, acc_d;

  logic           accept;
  logic [2:0]     dlast;
  logic           last_i, last_j;
  logic [4:0]     shamt;
  logic [AW-1:0]  pp;

  // Digit bookkeeping and shifted, sign-extended partial product
  always_comb begin
    accept = ready_q & bus.in_valid;
    dlast  = 3'((4'd1 << prec_q) - 4'd1);
    last_i = (i_q == dlast);
    last_j = (j_q == dlast);
    shamt  = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};
    pp     = {{(AW-5){bus.p[4]}}, bus.p} << shamt;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_i && last_j) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: capture at accept, step digits and accumulate in RUN
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sgn_a_d = sgn_a_q;
    sgn_b_d = sgn_b_q;
    prec_d  = prec_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    // in_ready is registered so it stays low during reset and rises one cycle later
    ready_d = (state_d == StIdle);
    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      sgn_a_d = bus.sgn_a;
      sgn_b_d = bus.sgn_b;
      // 16-bit precision does not exist on an 8-bit build; fall back to 8
      prec_d  = (OPW == 8 && bus.prec == 2'd3) ? 2'd2 : bus.prec;
      i_d     = '0;
      j_d     = '0;
`ifdef PSMAC_ACC_EN
      if (bus.acc_clr) acc_d = '0;
`else
      acc_d   = '0;
`endif
    end else if (state_q == StRun) begin
      acc_d = acc_q + pp;
      if (last_i) begin
        i_d = '0;
        j_d = last_j ? 3'd0 : j_q + 3'd1;
      end else begin
        i_d = i_q + 3'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_a_q <= 1'b0;
      sgn_b_q <= 1'b0;
      prec_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
    end else begin
      ready_q <= ready_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_a_q <= sgn_a_d;
      sgn_b_q <= sgn_b_d;
      prec_q  <= prec_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
    end
  end

`ifndef PSMAC_ACC_EN
  logic [5:0]    n2;
  logic [RW-1:0] lomask, topbit, res_v;
  logic          msb;

  // Re-extend the exact 2n-bit product to the full result width
  always_comb begin
    n2     = 6'd4 << prec_q;
    lomask = ~({RW{1'b1}} << n2);
    topbit = {{(RW-1){1'b0}}, 1'b1} << (n2 - 6'd1);
    msb    = |(acc_q & topbit);
    res_v  = acc_q & lomask;
    if ((sgn_a_q | sgn_b_q) && msb) res_v = res_v | ~lomask;
  end
`endif

  // Outputs: digit drive in RUN, product in DONE, zero elsewhere
  always_comb begin
    bus.in_ready  = ready_q;
    bus.md        = '0;
    bus.mr        = '0;
    bus.sx        = 1'b0;
    bus.sy        = 1'b0;
    bus.out_valid = 1'b0;
    bus.result    = '0;
    if (state_q == StRun) begin
      bus.md = 2'(a_q >> {i_q, 1'b0});
      bus.mr = 2'(b_q >> {j_q, 1'b0});
      bus.sx = sgn_a_q & last_i;
      bus.sy = sgn_b_q & last_j;
    end
    if (state_q == StDone) begin
      bus.out_valid = 1'b1;
`ifdef PSMAC_ACC_EN
      bus.result    = acc_q;
`else
      bus.result    = res_v;
`endif
    end
  end
endmodule

// File: tb/tb_digit_seq_mul.sv
// Self-checking bench for digit_seq_mul (OPW=8). Models the 2x2 building block, keeps an
// arithmetic reference of the handshake and product, and adds directed literal checks.
// Build with PSMAC_ACC_EN defined to exercise the accumulate mode as well.
module tb_digit_seq_mul;
`ifdef PSMAC_ACC_EN
  localparam int RES_W = 20;
`else
  localparam int RES_W = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  digit_seq_mul_if #(.OPW(8)) bus ();

  digit_seq_mul #(.OPW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // 2x2 signed/unsigned multiply building block
  int bb_x, bb_y;
  always_comb begin
    bb_x = int'(bus.md);
    bb_y = int'(bus.mr);
    if (bus.sx && bus.md[1]) bb_x = bb_x - 4;
    if (bus.sy && bus.mr[1]) bb_y = bb_y - 4;
    bus.p = 5'(bb_x * bb_y);
  end

  function automatic longint opval(input logic [7:0] v, input int n, input bit s);
    longint u;
    u = longint'(v) & ((longint'(1) << n) - 1);
    if (s && u >= (longint'(1) << (n - 1))) u = u - (longint'(1) << n);
    return u;
  endfunction

  // Reference model: phase 0 idle, 1 run, 2 done
  int               m_ph = 0, m_step = 0, m_d = 1, m_n;
  bit               m_rdy = 1'b0;
  logic [7:0]       m_a, m_b;
  bit               m_sa, m_sb;
  longint           m_prod;
  logic [RES_W-1:0] m_res;
  logic [RES_W-1:0] m_acc = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph  = 0;
      m_rdy = 1'b0;
      m_acc = '0;
    end else begin
      case (m_ph)
        0: if (m_rdy && bus.in_valid) begin
          m_n = 2 << bus.prec;
          if (m_n > 8) m_n = 8;
          m_d    = m_n / 2;
          m_a    = bus.a;
          m_b    = bus.b;
          m_sa   = bus.sgn_a;
          m_sb   = bus.sgn_b;
          m_prod = opval(m_a, m_n, m_sa) * opval(m_b, m_n, m_sb);
`ifdef PSMAC_ACC_EN
          if (bus.acc_clr) m_acc = '0;
          m_acc = m_acc + RES_W'(m_prod);
          m_res = m_acc;
`else
          m_res = RES_W'(m_prod);
`endif
          m_step = 0;
          m_ph   = 1;
        end
        1: if (m_step == m_d * m_d - 1) m_ph = 2; else m_step++;
        2: if (bus.out_ready) m_ph = 0;
        default: m_ph = 0;
      endcase
      m_rdy = (m_ph == 0);
    end
  end

  // Cycle-by-cycle comparison against the model
  int e_i, e_j;
  always @(negedge clk) begin
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ph == 2));
    if (m_ph == 1) begin
      e_i = m_step % m_d;
      e_j = m_step / m_d;
      chk("md", 32'(bus.md), 32'((int'(m_a) >> (2 * e_i)) & 3));
      chk("mr", 32'(bus.mr), 32'((int'(m_b) >> (2 * e_j)) & 3));
      chk("sx", 32'(bus.sx), 32'(m_sa && e_i == m_d - 1));
      chk("sy", 32'(bus.sy), 32'(m_sb && e_j == m_d - 1));
    end else begin
      chk("digits_idle", {28'd0, bus.md, bus.mr}, 32'd0);
      chk("signs_idle", {30'd0, bus.sx, bus.sy}, 32'd0);
    end
    if (m_ph == 2) chk("result_model", 32'(bus.result), 32'(m_res));
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit sa, input bit sb,
                       input logic [1:0] pr, input bit clr, input longint exp,
                       input int exp_lat, input int hold);
    int lat;
    logic [RES_W-1:0] e;
    e = RES_W'(exp);
    wait_ready();
    bus.a = a; bus.b = b; bus.sgn_a = sa; bus.sgn_b = sb; bus.prec = pr;
`ifdef PSMAC_ACC_EN
    bus.acc_clr = clr;
`else
    if (clr) bus.a = a;
`endif
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 8'h5A; bus.b = 8'hA5;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result_lit", 32'(bus.result), 32'(e));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_result", 32'(bus.result), 32'(e));
      chk("hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("valid_drop", 32'(bus.out_valid), 32'd0);
    chk("ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.sgn_a = 1'b0; bus.sgn_b = 1'b0; bus.prec = '0;
`ifdef PSMAC_ACC_EN
    bus.acc_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // T1 then T4: 3*3 at 2-bit, then same with result held for 5 cycles
    do_op(8'h03, 8'h03, 1'b0, 1'b0, 2'd0, 1'b1, 9, 2, 0);
    do_op(8'h03, 8'h03, 1'b0, 1'b0, 2'd0, 1'b1, 9, 2, 5);
    // T2: signed extreme -128 * -128
    do_op(8'h80, 8'h80, 1'b1, 1'b1, 2'd2, 1'b1, 16384, 17, 0);
    // T3: -3 (signed 4b) * 15 (unsigned 4b)
    do_op(8'h0D, 8'h0F, 1'b1, 1'b0, 2'd1, 1'b1, -45, 5, 0);
    // Upper operand bits ignored at 4-bit precision: 7 * 9
    do_op(8'hF7, 8'h39, 1'b0, 1'b0, 2'd1, 1'b1, 63, 5, 0);
    // prec=3 behaves as 8-bit on this build: 255 * 2
    do_op(8'hFF, 8'h02, 1'b0, 1'b0, 2'd3, 1'b1, 510, 17, 0);
    // Mixed: -1 (signed 8b) * 127 (unsigned 8b)
    do_op(8'hFF, 8'h7F, 1'b1, 1'b0, 2'd2, 1'b1, -127, 17, 0);
    // Signed 2-bit: -2 * 1
    do_op(8'h02, 8'h01, 1'b1, 1'b1, 2'd0, 1'b1, -2, 2, 0);

    // T5: reset during RUN cycle 7
    wait_ready();
    bus.a = 8'h12; bus.b = 8'h34; bus.sgn_a = 1'b0; bus.sgn_b = 1'b0; bus.prec = 2'd2;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_digits", {26'd0, bus.md, bus.mr, bus.sx, bus.sy}, 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 2'd2, 1'b1, 65025, 17, 0);

`ifdef PSMAC_ACC_EN
    // T6: accumulate across operations
    do_op(8'h03, 8'h03, 1'b0, 1'b0, 2'd0, 1'b1, 9, 2, 0);
    do_op(8'h02, 8'h02, 1'b0, 1'b0, 2'd0, 1'b0, 13, 2, 0);
    do_op(8'h02, 8'h02, 1'b0, 1'b0, 2'd0, 1'b1, 4, 2, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
